// File: rtl/lab_pkg.sv
// Shared definitions for the NOR-network sweep checker: state encoding,
// the golden truth table of the four-input NOR network and the width
// helper for the mismatch counter.
package lab_pkg;

   // Sweep sequencer states; the encoding is fixed so the lab top level
   // can decode the state onto debug LEDs.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } SweepState;

   // Geometry of the NOR network the default table describes.
   localparam int NOR_N_IN  = 4;
   localparam int NOR_N_OUT = 3;

   // Expected {G,F,E} for every pattern {D,C,B,A}, pattern p in bits
   // [p*3 +: 3], with E=NOR(A,B), F=NOR(C,D), G=NOR(E,F).
   // Listed from pattern 15 down to pattern 0.
   localparam logic [NOR_N_OUT*(2**NOR_N_IN)-1:0] NOR_EXP_TABLE = {
      3'd4, 3'd4, 3'd4, 3'd1,
      3'd4, 3'd4, 3'd4, 3'd1,
      3'd4, 3'd4, 3'd4, 3'd1,
      3'd2, 3'd2, 3'd2, 3'd3
   };

   // Bits needed to count every pattern failing, i.e. values 0..2^nIn.
   function automatic int errCntWidth(input int nIn);
      return $clog2((1 << nIn) + 1);
   endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter with a zero flag. The sweep sequencer loads it
// with the settle length minus one when a new stimulus goes out and lets
// it count down while waiting for the DUT outputs to settle.
module sweep_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_loadVal,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   // Load takes priority over counting; the counter parks at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/nor_sweep_checker.sv
// Hardware sweep checker: walks a small combinational DUT through every
// input pattern, waits for its outputs to settle, compares them with a
// golden truth table and keeps a mismatch count plus the first failing
// pattern for the LEDs / 7-segment display.
module nor_sweep_checker
   import lab_pkg::*;
#(
   parameter int N_IN   = NOR_N_IN,
   parameter int N_OUT  = NOR_N_OUT,
   parameter int SETTLE = 2,
   parameter logic [N_OUT*(2**N_IN)-1:0] EXP_TABLE = NOR_EXP_TABLE
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic [N_IN-1:0]              stim,
   input  logic [N_OUT-1:0]             resp,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [errCntWidth(N_IN)-1:0] err_cnt,
   output logic                         first_err_valid,
   output logic [N_IN-1:0]              first_err_idx
);

   localparam int ERR_W = errCntWidth(N_IN);

   SweepState          r_state;
   SweepState          w_nextState;
   logic [N_IN-1:0]    r_idx;
   logic [ERR_W-1:0]   r_errCnt;
   logic               r_firstValid;
   logic [N_IN-1:0]    r_firstIdx;

   logic               w_startSweep;
   logic               w_sampleNow;
   logic               w_loadTimer;
   logic               w_timerEn;
   logic               w_timerZero;
   logic               w_lastIdx;
   logic [N_OUT-1:0]   w_expected;
   logic               w_mismatch;
   logic               w_busy;
   logic               w_done;

   assign w_lastIdx  = (r_idx == {N_IN{1'b1}});
   assign w_expected = EXP_TABLE[r_idx*N_OUT +: N_OUT];
   assign w_mismatch = (resp != w_expected);

   // The settle wait is SETTLE cycles: loading SETTLE-1 makes the zero
   // flag appear in the last settle cycle, so SAMPLE follows immediately.
   sweep_settle_timer #(
      .W(4)
   ) u_settleTimer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_loadTimer),
      .i_loadVal(4'(SETTLE - 1)),
      .i_en     (w_timerEn),
      .o_zero   (w_timerZero)
   );

   // State register; reset abandons any sweep in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: start is only honoured from IDLE or DONE.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_nextState = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (w_timerZero) begin
               w_nextState = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            w_nextState = w_lastIdx ? ST_DONE : ST_SETTLE;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Output and control decode from the current state.
   always_comb begin
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_startSweep = 1'b0;
      w_sampleNow  = 1'b0;
      w_timerEn    = 1'b0;
      w_loadTimer  = 1'b0;
      unique case (r_state)
         ST_IDLE, ST_DONE: begin
            w_done       = (r_state == ST_DONE);
            w_startSweep = start;
            w_loadTimer  = start;
         end
         ST_SETTLE: begin
            w_busy    = 1'b1;
            w_timerEn = 1'b1;
         end
         ST_SAMPLE: begin
            w_busy      = 1'b1;
            w_sampleNow = 1'b1;
            w_loadTimer = !w_lastIdx;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   // Pattern index and error bookkeeping; a new sweep clears old results.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx        <= '0;
         r_errCnt     <= '0;
         r_firstValid <= 1'b0;
         r_firstIdx   <= '0;
      end else if (w_startSweep) begin
         r_idx        <= '0;
         r_errCnt     <= '0;
         r_firstValid <= 1'b0;
         r_firstIdx   <= '0;
      end else if (w_sampleNow) begin
         if (w_mismatch) begin
            r_errCnt <= r_errCnt + ERR_W'(1);
            if (!r_firstValid) begin
               r_firstValid <= 1'b1;
               r_firstIdx   <= r_idx;
            end
         end
         if (!w_lastIdx) begin
            r_idx <= r_idx + N_IN'(1);
         end
      end
   end

   assign stim            = r_idx;
   assign busy            = w_busy;
   assign done            = w_done;
   assign pass            = w_done && (r_errCnt == '0);
   assign err_cnt         = r_errCnt;
   assign first_err_valid = r_firstValid;
   assign first_err_idx   = r_firstIdx;

endmodule

// File: tb/tb_nor_sweep_checker.sv
// Bench for nor_sweep_checker: a behavioural NOR network (with optional
// planted faults) answers the checker's stimulus, a scoreboard queue holds
// the hand-computed outcome of each sweep and a monitor compares when the
// checker reports done.
module tb_nor_sweep_checker;

   localparam int SWEEP_CYCLES = 48;
   localparam int PAT_CYCLES   = 3;

   typedef struct {
      int errCnt;
      int firstValid;
      int firstIdx;
      int passV;
   } ExpResult;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] stim;
   logic [2:0] resp;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_cnt;
   logic       first_err_valid;
   logic [3:0] first_err_idx;

   int         errors;
   int         checks;
   int         cycleCnt;
   int         t0;
   bit         trackActive;
   bit         prevDone;
   int         faultMode;
   ExpResult   scoreQ[$];

   logic       mA, mB, mC, mD, mE, mF, mG;

   nor_sweep_checker #(
      .N_IN  (4),
      .N_OUT (3),
      .SETTLE(2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .stim           (stim),
      .resp           (resp),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .first_err_valid(first_err_valid),
      .first_err_idx  (first_err_idx)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency and stimulus-step expectations.
   always @(posedge clk) begin
      cycleCnt++;
   end

   // Gate-level model of the NOR network; mode 1 holds E at 0, mode 2
   // inverts G for pattern 9 only.
   always_comb begin
      mA = stim[0];
      mB = stim[1];
      mC = stim[2];
      mD = stim[3];
      mE = ~(mA | mB);
      mF = ~(mC | mD);
      mG = ~(mE | mF);
      if (faultMode == 1) begin
         mE = 1'b0;
      end
      if ((faultMode == 2) && (stim == 4'd9)) begin
         mG = ~mG;
      end
      resp = {mG, mF, mE};
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: follows the stimulus steps of a tracked sweep and pops the
   // scoreboard when done rises.
   always @(negedge clk) begin : monitor
      int e;
      if (trackActive) begin
         e = cycleCnt - t0;
         if (done && !prevDone) begin
            if (scoreQ.size() == 0) begin
               checkOutput("unexpectedDone", 1, 0);
            end else begin
               ExpResult x;
               x = scoreQ.pop_front();
               checkOutput("doneLatency", e, SWEEP_CYCLES);
               checkOutput("errCnt", int'(err_cnt), x.errCnt);
               checkOutput("firstErrValid", int'(first_err_valid), x.firstValid);
               checkOutput("firstErrIdx", int'(first_err_idx), x.firstIdx);
               checkOutput("pass", int'(pass), x.passV);
               checkOutput("busyAtDone", int'(busy), 0);
            end
            trackActive = 1'b0;
         end else if (!done && (e < SWEEP_CYCLES)) begin
            checkOutput("stimStep", int'(stim), e / PAT_CYCLES);
            checkOutput("busyInSweep", int'(busy), 1);
         end
      end
      prevDone = done;
   end

   // Issue a start, record the expected outcome and wait (bounded) for done;
   // optionally keeps pulsing start while the sweep runs.
   task automatic applyStimulus(input int mode, input int expErr, input int expFV,
                                input int expFI, input int expPass, input bit pulseBusy);
      ExpResult r;
      bit       gotDone;
      faultMode    = mode;
      r.errCnt     = expErr;
      r.firstValid = expFV;
      r.firstIdx   = expFI;
      r.passV      = expPass;
      scoreQ.push_back(r);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      t0          = cycleCnt;
      trackActive = 1'b1;
      start       = 1'b0;
      checkOutput("startClrDone", int'(done), 0);
      checkOutput("startClrErr", int'(err_cnt), 0);
      checkOutput("startStim", int'(stim), 0);
      gotDone = 1'b0;
      for (int c = 0; (c < 200) && !gotDone; c++) begin
         @(negedge clk);
         if (done) begin
            gotDone = 1'b1;
            start   = 1'b0;
         end else if (pulseBusy && (((cycleCnt - t0) % 7) == 3)) begin
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (!gotDone) begin
         checkOutput("doneTimeout", 0, 1);
         trackActive = 1'b0;
      end
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      cycleCnt    = 0;
      t0          = 0;
      trackActive = 1'b0;
      prevDone    = 1'b0;
      faultMode   = 0;
      start       = 1'b0;
      rst_n       = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstStim", int'(stim), 0);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstPass", int'(pass), 0);
      checkOutput("rstErrCnt", int'(err_cnt), 0);
      checkOutput("rstFirstValid", int'(first_err_valid), 0);
      checkOutput("rstFirstIdx", int'(first_err_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idleHoldBusy", int'(busy), 0);

      $display("[TB] golden sweep");
      applyStimulus(0, 0, 0, 0, 1, 1'b0);

      $display("[TB] E stuck at 0");
      applyStimulus(1, 4, 1, 0, 0, 1'b0);

      $display("[TB] G inverted at pattern 9, then rerun from done");
      applyStimulus(2, 1, 1, 9, 0, 1'b0);
      applyStimulus(2, 1, 1, 9, 0, 1'b0);

      $display("[TB] reset during pattern 6 settle");
      faultMode = 1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      t0          = cycleCnt;
      trackActive = 1'b1;
      start       = 1'b0;
      repeat (19) @(negedge clk);
      checkOutput("abortStimAt6", int'(stim), 6);
      checkOutput("abortPartialErr", int'(err_cnt), 2);
      trackActive = 1'b0;
      rst_n       = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abortStim", int'(stim), 0);
      checkOutput("abortBusy", int'(busy), 0);
      checkOutput("abortDone", int'(done), 0);
      checkOutput("abortErrCnt", int'(err_cnt), 0);
      checkOutput("abortFirstValid", int'(first_err_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 1, 1'b0);

      $display("[TB] start pulsed while busy");
      applyStimulus(2, 1, 1, 9, 0, 1'b1);

      repeat (2) @(negedge clk);
      checkOutput("scoreboardDrained", scoreQ.size(), 0);
      checkOutput("doneHeld", int'(done), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
